// File: rtl/nvme_ctl_pkg.sv
// Shared constants, types and the doorbell address helper for the NVMe doorbell controller.
package nvme_ctl_pkg;

    localparam logic [3:0] ST_WAIT_LNKUP   = 4'd0;
    localparam logic [3:0] ST_START_CFG    = 4'd1;
    localparam logic [3:0] ST_WAIT_CFG_DONE = 4'd2;
    localparam logic [3:0] ST_IDLE         = 4'd3;
    localparam logic [3:0] ST_ISSUE        = 4'd4;
    localparam logic [3:0] ST_WAIT_DONE    = 4'd5;

    localparam logic [63:0] DB_OFFSET = 64'h1000;

    // Doorbell k = 2*q + type
    localparam int DB_SQ = 0;
    localparam int DB_CQ = 1;

    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] data;
    } db_req_t;

    function automatic logic [63:0] db_address(input logic [63:0] base, input int unsigned k,
                                               input int unsigned dstrd);
        return base + DB_OFFSET + (64'(k) << (2 + dstrd));
    endfunction

endpackage

// File: rtl/nvme_rr_arbiter.sv
// Round-robin arbiter: search begins one past the last granted index; pointer moves on adv.
module nvme_rr_arbiter #(
    parameter int N = 8,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          adv,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt_oh,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);

    logic [IW-1:0] start_q, start_d;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int i = 0; i < N; i++) begin
            int j;
            logic [IW-1:0] jj;
            j = int'(start_q) + i;
            if (j >= N) j = j - N;
            jj = IW'(j);
            if (!gnt_vld && req[jj]) begin
                gnt_vld    = 1'b1;
                gnt_idx    = jj;
                gnt_oh[jj] = 1'b1;
            end
        end
    end

    always_comb begin
        start_d = start_q;
        if (clr) start_d = '0;
        else if (adv && gnt_vld) start_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) start_q <= '0;
        else        start_q <= start_d;
    end

endmodule

// File: rtl/nvme_multiq_doorbell_ctrl.sv
// Multi-queue NVMe doorbell controller: bring-up FSM, SQ tail / CQ head tracking, coalesced doorbell writes.
// Optional doorbell-done watchdog enabled by defining DB_TIMEOUT_EN.
module nvme_multiq_doorbell_ctrl
    import nvme_ctl_pkg::*;
#(
    parameter int          NUM_QUEUES  = 4,
    parameter int          QUEUE_DEPTH = 64,
    parameter int          PTR_W       = $clog2(QUEUE_DEPTH),
    parameter int          DSTRD       = 0,
    parameter logic [63:0] BAR_BASE    = 64'h0000_0800_0000_0000,
    parameter int          TIMEOUT_CYC = 1024
) (
    input  logic                        user_clk,
    input  logic                        user_reset_n,
    input  logic                        user_lnk_up,
    output logic                        start_config,
    input  logic                        cfg_done,
    input  logic [NUM_QUEUES-1:0]       sq_submit,
    input  logic [NUM_QUEUES-1:0]       cq_consume,
    input  logic [NUM_QUEUES*PTR_W-1:0] sq_head,
    output logic [NUM_QUEUES-1:0]       sq_full,
    output logic                        db_write,
    output logic [63:0]                 db_addr,
    output logic [31:0]                 db_data,
    input  logic                        db_write_done,
    output logic                        overflow_err,
    output logic                        db_timeout,
    output logic [3:0]                  ctl_state
);

    localparam int NUM_DB = 2 * NUM_QUEUES;
    localparam int IW     = $clog2(NUM_DB);

    logic [3:0]                   state_q, state_d;
    logic                         start_cfg_q, start_cfg_d;
    logic                         db_write_q, db_write_d;
    db_req_t                      req_q, req_d;
    logic                         ovf_q, ovf_d;
    logic [IW-1:0]                gidx_q, gidx_d;
    logic [PTR_W-1:0]             lat_q, lat_d;
    logic [NUM_DB-1:0][PTR_W-1:0] ptr_q, ptr_d;
    logic [NUM_DB-1:0][PTR_W-1:0] last_q, last_d;

    logic [NUM_DB-1:0] pending;
    logic [NUM_DB-1:0] gnt_oh;
    logic [IW-1:0]     gnt_idx;
    logic              gnt_vld;
    logic              adv;
    logic [PTR_W-1:0]  gnt_ptr;
    logic              active;

    for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_q
        assign sq_full[q] = (PTR_W'(ptr_q[2*q+DB_SQ] + 1'b1) == sq_head[q*PTR_W +: PTR_W]);
    end

    for (genvar k = 0; k < NUM_DB; k++) begin : g_pend
        assign pending[k] = (ptr_q[k] != last_q[k]);
    end

    nvme_rr_arbiter #(.N(NUM_DB)) u_arb (
        .clk     (user_clk),
        .rst_n   (user_reset_n),
        .clr     (!user_lnk_up),
        .adv     (adv),
        .req     (pending),
        .gnt_oh  (gnt_oh),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    always_comb begin
        gnt_ptr = '0;
        for (int k = 0; k < NUM_DB; k++) if (gnt_oh[k]) gnt_ptr = gnt_ptr | ptr_q[k];
    end

    assign active = (state_q == ST_IDLE) || (state_q == ST_ISSUE) || (state_q == ST_WAIT_DONE);

`ifdef DB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_flag_q, tmo_flag_d;
`else
    // Watchdog length is meaningless without the watchdog; keep the parameter referenced.
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

    always_comb begin
        state_d     = state_q;
        start_cfg_d = 1'b0;
        db_write_d  = 1'b0;
        req_d       = req_q;
        ovf_d       = ovf_q;
        gidx_d      = gidx_q;
        lat_d       = lat_q;
        ptr_d       = ptr_q;
        last_d      = last_q;
        adv         = 1'b0;
`ifdef DB_TIMEOUT_EN
        tmo_d       = '0;
        tmo_flag_d  = tmo_flag_q;
`endif
        if (!user_lnk_up) begin
            state_d = ST_WAIT_LNKUP;
            req_d   = '0;
            ovf_d   = 1'b0;
            gidx_d  = '0;
            lat_d   = '0;
            ptr_d   = '0;
            last_d  = '0;
`ifdef DB_TIMEOUT_EN
            tmo_flag_d = 1'b0;
`endif
        end else begin
            start_cfg_d = (state_q == ST_START_CFG);
            if (active) begin
                for (int q = 0; q < NUM_QUEUES; q++) begin
                    if (sq_submit[q]) begin
                        if (sq_full[q]) ovf_d = 1'b1;
                        else            ptr_d[2*q+DB_SQ] = ptr_q[2*q+DB_SQ] + 1'b1;
                    end
                    if (cq_consume[q]) ptr_d[2*q+DB_CQ] = ptr_q[2*q+DB_CQ] + 1'b1;
                end
            end
            case (state_q)
                ST_WAIT_LNKUP:    state_d = ST_START_CFG;
                ST_START_CFG:     state_d = ST_WAIT_CFG_DONE;
                ST_WAIT_CFG_DONE: if (cfg_done) state_d = ST_IDLE;
                ST_IDLE: begin
                    if (gnt_vld) begin
                        adv        = 1'b1;
                        state_d    = ST_ISSUE;
                        db_write_d = 1'b1;
                        gidx_d     = gnt_idx;
                        lat_d      = gnt_ptr;
                        req_d.addr = db_address(BAR_BASE, 32'(gnt_idx), 32'(DSTRD));
                        req_d.data = 32'(gnt_ptr);
                    end
                end
                ST_ISSUE: begin
                    if (db_write_done) begin
                        last_d[gidx_q] = lat_q;
                        state_d        = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (db_write_done) begin
                        last_d[gidx_q] = lat_q;
                        state_d        = ST_IDLE;
                    end
`ifdef DB_TIMEOUT_EN
                    // last_w is left alone so the same doorbell competes again
                    else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                        tmo_flag_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
`endif
                end
                default: state_d = ST_WAIT_LNKUP;
            endcase
        end
    end

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            state_q     <= ST_WAIT_LNKUP;
            start_cfg_q <= 1'b0;
            db_write_q  <= 1'b0;
            req_q       <= '0;
            ovf_q       <= 1'b0;
            gidx_q      <= '0;
            lat_q       <= '0;
            ptr_q       <= '0;
            last_q      <= '0;
        end else begin
            state_q     <= state_d;
            start_cfg_q <= start_cfg_d;
            db_write_q  <= db_write_d;
            req_q       <= req_d;
            ovf_q       <= ovf_d;
            gidx_q      <= gidx_d;
            lat_q       <= lat_d;
            ptr_q       <= ptr_d;
            last_q      <= last_d;
        end
    end

`ifdef DB_TIMEOUT_EN
    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            tmo_q      <= '0;
            tmo_flag_q <= 1'b0;
        end else begin
            tmo_q      <= tmo_d;
            tmo_flag_q <= tmo_flag_d;
        end
    end
    assign db_timeout = tmo_flag_q;
`else
    assign db_timeout = 1'b0;
`endif

    assign start_config = start_cfg_q;
    assign db_write     = db_write_q;
    assign db_addr      = req_q.addr;
    assign db_data      = req_q.data;
    assign overflow_err = ovf_q;
    assign ctl_state    = state_q;

endmodule

// File: tb/tb_nvme_multiq_doorbell_ctrl.sv
// Scoreboard bench: two DUTs (DSTRD 0 and 1, depth 4) in lockstep; monitors check every doorbell write.
module tb_nvme_multiq_doorbell_ctrl;

    localparam int          NQ   = 4;
    localparam int          PW   = 2;
    localparam logic [63:0] BASE = 64'h0000_0800_0000_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          lnk_up = 1'b0;
    logic          cfg_done = 1'b0;
    logic          db_write_done = 1'b0;
    logic [NQ-1:0] sq_submit = '0;
    logic [NQ-1:0] cq_consume = '0;
    logic [NQ*PW-1:0] sq_head = '0;

    logic          start_a, wr_a, ovf_a, tmo_a;
    logic [NQ-1:0] full_a;
    logic [63:0]   addr_a;
    logic [31:0]   data_a;
    logic [3:0]    ctl_a;
    logic          start_b, wr_b, ovf_b, tmo_b;
    logic [NQ-1:0] full_b;
    logic [63:0]   addr_b;
    logic [31:0]   data_b;
    logic [3:0]    ctl_b;

    int   checks = 0;
    int   failures = 0;
    logic auto_done = 1'b1;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    always #5 clk = ~clk;

    nvme_multiq_doorbell_ctrl #(.NUM_QUEUES(NQ), .QUEUE_DEPTH(4), .DSTRD(0)) dut_a (
        .user_clk(clk), .user_reset_n(rst_n), .user_lnk_up(lnk_up), .start_config(start_a),
        .cfg_done(cfg_done), .sq_submit(sq_submit), .cq_consume(cq_consume), .sq_head(sq_head),
        .sq_full(full_a), .db_write(wr_a), .db_addr(addr_a), .db_data(data_a),
        .db_write_done(db_write_done), .overflow_err(ovf_a), .db_timeout(tmo_a), .ctl_state(ctl_a));

    nvme_multiq_doorbell_ctrl #(.NUM_QUEUES(NQ), .QUEUE_DEPTH(4), .DSTRD(1)) dut_b (
        .user_clk(clk), .user_reset_n(rst_n), .user_lnk_up(lnk_up), .start_config(start_b),
        .cfg_done(cfg_done), .sq_submit(sq_submit), .cq_consume(cq_consume), .sq_head(sq_head),
        .sq_full(full_b), .db_write(wr_b), .db_addr(addr_b), .db_data(data_b),
        .db_write_done(db_write_done), .overflow_err(ovf_b), .db_timeout(tmo_b), .ctl_state(ctl_b));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_a) begin
            if (qa.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_write_a: addr %0h data %0h", addr_a, data_a);
            end else begin
                ea = qa.pop_front();
                chk("wr_a_addr", addr_a, ea.addr);
                chk("wr_a_data", 64'(data_a), 64'(ea.data));
            end
        end
        if (wr_b) begin
            if (qb.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_write_b: addr %0h data %0h", addr_b, data_b);
            end else begin
                eb = qb.pop_front();
                chk("wr_b_addr", addr_b, eb.addr);
                chk("wr_b_data", 64'(data_b), 64'(eb.data));
            end
        end
    end

    // Write engine model: acknowledges in the ISSUE cycle when auto_done is set
    always @(negedge clk) if (auto_done) db_write_done = wr_a;

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input int k, input logic [31:0] d);
        exp_t e;
        e.data = d;
        e.addr = BASE + 64'h1000 + (64'(k) << 2);
        qa.push_back(e);
        e.addr = BASE + 64'h1000 + (64'(k) << 3);
        qb.push_back(e);
    endtask

    task automatic wait_state(input logic [3:0] s, input int max);
        int n = 0;
        while (ctl_a != s && n < max) begin tick(); n++; end
        chk("wait_state", 64'(ctl_a), 64'(s));
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0 || ctl_a != 4'd3) && n < max) begin tick(); n++; end
        repeat (4) tick();
        chk("drain_a", 64'(qa.size()), 64'd0);
        chk("drain_b", 64'(qb.size()), 64'd0);
        chk("drain_idle", 64'(ctl_a), 64'd3);
    endtask

    task automatic pulse(input logic [NQ-1:0] sqm, input logic [NQ-1:0] cqm);
        sq_submit = sqm; cq_consume = cqm;
        tick();
        sq_submit = '0; cq_consume = '0;
    endtask

    task automatic bringup();
        lnk_up = 1'b1;
        tick();
        chk("bring_state1", 64'(ctl_a), 64'd1);
        chk("bring_start_lo", 64'(start_a), 64'd0);
        tick();
        chk("bring_state2", 64'(ctl_a), 64'd2);
        chk("bring_start_hi", 64'(start_a), 64'd1);
        tick();
        chk("bring_start_pulse", 64'(start_a), 64'd0);
        repeat (4) tick();
        chk("bring_wait_cfg", 64'(ctl_a), 64'd2);
        cfg_done = 1'b1;
        tick();
        cfg_done = 1'b0;
        chk("bring_idle", 64'(ctl_a), 64'd3);
        chk("bring_idle_b", 64'(ctl_b), 64'd3);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_state", 64'(ctl_a), 64'd0);
        chk("rst_start", 64'(start_a), 64'd0);
        chk("rst_write", 64'(wr_a), 64'd0);
        chk("rst_addr", addr_a, 64'd0);
        chk("rst_data", 64'(data_a), 64'd0);
        chk("rst_ovf", 64'(ovf_a), 64'd0);
        chk("rst_full", 64'(full_a), 64'd0);
        chk("rst_tmo", 64'(tmo_a), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("lnkdown_hold", 64'(ctl_a), 64'd0);
        bringup();

        // single submit on q1 -> doorbell k=2
        expect_wr(2, 32'd1);
        pulse(4'b0010, 4'b0000);
        drain(50);
`ifndef DB_TIMEOUT_EN
        chk("tmo_tied0", 64'(tmo_a), 64'd0);
`endif

        // coalesce three SQ0 submits while stalled on CQ0 (k=1)
        auto_done = 1'b0;
        expect_wr(1, 32'd1);
        pulse(4'b0000, 4'b0001);
        wait_state(4'd5, 20);
        expect_wr(0, 32'd3);
        pulse(4'b0001, 4'b0000);
        pulse(4'b0001, 4'b0000);
        pulse(4'b0001, 4'b0000);
        repeat (3) tick();
        chk("stall_hold", 64'(ctl_a), 64'd5);
        db_write_done = 1'b1;
        tick();
        db_write_done = 1'b0;
        auto_done = 1'b1;
        drain(50);

        // full / overflow / wrap with depth 4
        chk("full_at3", 64'(full_a), 64'b0001);
        chk("ovf_before", 64'(ovf_a), 64'd0);
        pulse(4'b0001, 4'b0000);
        tick();
        chk("ovf_set", 64'(ovf_a), 64'd1);
        chk("full_still", 64'(full_a), 64'b0001);
        drain(20);
        sq_head[PW-1:0] = 2'd1;
        #1;
        chk("full_clear", 64'(full_a), 64'b0000);
        expect_wr(0, 32'd0);
        pulse(4'b0001, 4'b0000);
        drain(50);
        chk("ovf_sticky", 64'(ovf_a), 64'd1);
        sq_head = '0;

        // link drop during WAIT_DONE
        auto_done = 1'b0;
        expect_wr(4, 32'd1);
        pulse(4'b0100, 4'b0000);
        wait_state(4'd5, 20);
        lnk_up = 1'b0;
        tick();
        chk("lnk_state", 64'(ctl_a), 64'd0);
        chk("lnk_state_b", 64'(ctl_b), 64'd0);
        chk("lnk_addr", addr_a, 64'd0);
        chk("lnk_data", 64'(data_a), 64'd0);
        chk("lnk_ovf", 64'(ovf_a), 64'd0);
        chk("lnk_full", 64'(full_a), 64'd0);
        chk("lnk_write", 64'(wr_a), 64'd0);
        auto_done = 1'b1;
        tick();
        bringup();
        drain(20);

        // all eight doorbells at once -> strict k order from 0
        for (int k = 0; k < 8; k++) expect_wr(k, 32'd1);
        pulse(4'b1111, 4'b1111);
        drain(200);

        // submit coincident with done gives one more write
        auto_done = 1'b0;
        expect_wr(0, 32'd2);
        pulse(4'b0001, 4'b0000);
        wait_state(4'd5, 20);
        expect_wr(0, 32'd3);
        sq_submit = 4'b0001;
        db_write_done = 1'b1;
        tick();
        sq_submit = '0;
        db_write_done = 1'b0;
        auto_done = 1'b1;
        drain(50);

`ifdef DB_TIMEOUT_EN
        auto_done = 1'b0;
        expect_wr(2, 32'd2);
        expect_wr(2, 32'd2);
        pulse(4'b0010, 4'b0000);
        wait_state(4'd5, 20);
        repeat (1030) tick();
        chk("tmo_flag", 64'(tmo_a), 64'd1);
        wait_state(4'd5, 20);
        db_write_done = 1'b1;
        tick();
        db_write_done = 1'b0;
        auto_done = 1'b1;
        drain(50);
`endif

        // async reset during WAIT_DONE
        auto_done = 1'b0;
        expect_wr(7, 32'd2);
        pulse(4'b0000, 4'b1000);
        wait_state(4'd5, 20);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", 64'(ctl_a), 64'd0);
        chk("arst_state_b", 64'(ctl_b), 64'd0);
        chk("arst_addr", addr_a, 64'd0);
        chk("arst_data", 64'(data_a), 64'd0);
        chk("arst_write", 64'(wr_a), 64'd0);
        chk("arst_ovf", 64'(ovf_b), 64'd0);
        tick();
        chk("sb_empty_a", 64'(qa.size()), 64'd0);
        chk("sb_empty_b", 64'(qb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
